tone_player: RTL and testbench

//  Consumes the 27-bit note words read out of note memory and drives the speaker.

---
 rtl/tone_player_pkg.sv | 21 ++
 rtl/tone_pwm.sv | 21 ++
 rtl/tone_player.sv | 131 +++++++++++++
 tb/tb_tone_player.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tone_player_pkg.sv
// Shared types and constants for the tone player.
// Note words are half-periods in clk cycles; zero means rest.
package tone_player_pkg;

  localparam int NOTE_W = 27;
  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RELEASE
  } state_t;

  function automatic logic [NOTE_W-1:0] clamp_half(
    input logic [NOTE_W-1:0] n,
    input logic [NOTE_W-1:0] lo
  );
    return (n < lo) ? lo : n;
  endfunction

endpackage

// File: rtl/tone_pwm.sv
// Free-running PWM counter; pwm_on while the counter is below level.
// A level of zero keeps pwm_on low.
module tone_pwm #(
  parameter int LEVEL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] level,
  output logic               pwm_on
);

  logic [LEVEL_W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + LEVEL_W'(1);
  end

  assign pwm_on = (pwm_cnt < level);

endmodule

// File: rtl/tone_player.sv
// Square-wave note player with one pending note slot and a linear
// release fade; new notes only take effect on half-period boundaries.
module tone_player
  import tone_player_pkg::*;
#(
  parameter int LEVEL_W      = 4,
  parameter int RELEASE_STEP = 50000,
  parameter int MIN_HALF     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NOTE_W-1:0]  note,
  input  logic               note_valid,
  output logic               note_ready,
  output logic               spk,
  output logic               tone_out,
  output logic [LEVEL_W-1:0] level,
  output logic               playing
);

  localparam int STEP_W =
    (RELEASE_STEP > 1) ? $clog2(RELEASE_STEP) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST =
    STEP_W'(RELEASE_STEP - 1);
  localparam logic [NOTE_W-1:0] MIN_H = NOTE_W'(MIN_HALF);
  localparam logic [LEVEL_W-1:0] FULL = '1;

  state_t              state;
  logic [NOTE_W-1:0]   half;
  logic [NOTE_W-1:0]   cnt;
  logic [NOTE_W-1:0]   pending;
  logic                pending_full;
  logic [STEP_W-1:0]   step;
  logic [LEVEL_W-1:0]  level_q;
  logic                tone_q;
  logic                pwm_on;

  logic [NOTE_W-1:0]   half_m1;
  logic                accept;
  logic                boundary;
  logic                load_new;
  logic                step_end;
  logic                fade_done;

  assign note_ready = !pending_full;
  assign accept     = note_valid && note_ready;
  assign half_m1    = half - NOTE_W'(1);
  assign boundary   = (state != IDLE) && (cnt == half_m1);
  assign load_new   = boundary && pending_full
                   && (pending != NOTE_REST);
  assign step_end   = (state == RELEASE) && (step == STEP_LAST);
  assign fade_done  = step_end && !load_new
                   && (level_q == LEVEL_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      half         <= '0;
      cnt          <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      step         <= '0;
      level_q      <= '0;
      tone_q       <= 1'b0;
    end else begin
      if (accept && state != IDLE) begin
        pending      <= note;
        pending_full <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (accept && note != NOTE_REST) begin
            state   <= PLAY;
            half    <= clamp_half(note, MIN_H);
            cnt     <= '0;
            tone_q  <= 1'b1;
            level_q <= FULL;
            step    <= '0;
          end
        end
        PLAY, RELEASE: begin
          if (boundary) begin
            cnt    <= '0;
            tone_q <= !tone_q;
            if (pending_full) pending_full <= 1'b0;
          end else begin
            cnt <= cnt + NOTE_W'(1);
          end
          if (load_new) begin
            state   <= PLAY;
            half    <= clamp_half(pending, MIN_H);
            level_q <= FULL;
            step    <= '0;
          end else if (state == PLAY) begin
            if (boundary && pending_full) state <= RELEASE;
            step <= '0;
          end else if (fade_done) begin
            // a word still queued when the fade ends is dropped
            state        <= IDLE;
            tone_q       <= 1'b0;
            cnt          <= '0;
            level_q      <= '0;
            step         <= '0;
            pending_full <= 1'b0;
          end else if (step_end) begin
            step    <= '0;
            level_q <= level_q - LEVEL_W'(1);
          end else begin
            step <= step + STEP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tone_pwm #(
    .LEVEL_W (LEVEL_W)
  ) u_pwm (
    .clk    (clk),
    .reset  (reset),
    .level  (level_q),
    .pwm_on (pwm_on)
  );

  assign tone_out = tone_q;
  assign level    = level_q;
  assign playing  = (state != IDLE);
  assign spk      = tone_q && pwm_on;

endmodule

// File: tb/tb_tone_player.sv
// Scoreboarded bench for tone_player: directed scenarios then random
// note traffic, checked cycle by cycle against a countdown model.
module tb_tone_player;
  import tone_player_pkg::*;

  localparam int LW   = 4;
  localparam int RS   = 8;
  localparam int MH   = 2;
  localparam int FULL = (1 << LW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NOTE_W-1:0] note;
  logic              note_valid;
  logic              note_ready;
  logic              spk;
  logic              tone_out;
  logic [LW-1:0]     level;
  logic              playing;

  always #5 clk = ~clk;

  tone_player #(
    .LEVEL_W      (LW),
    .RELEASE_STEP (RS),
    .MIN_HALF     (MH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .note       (note),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .spk        (spk),
    .tone_out   (tone_out),
    .level      (level),
    .playing    (playing)
  );

  typedef struct {
    bit spk;
    bit tone;
    bit playing;
    bit ready;
    int level;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mon_cyc  = 0;

  // reference model: remaining cycles in the current half-period,
  // cycles elapsed since the fade began, and a level that follows them
  bit m_act, m_rel, m_tone, m_pf;
  int m_half, m_left, m_elapsed, m_level, m_pend, m_pwm;

  task model_step(input bit rst, input bit v, input int n);
    begin : step_blk
      bit acc;
      bit was_rel;
      bit loaded;
      exp_t e;
      if (rst) begin
        m_act = 0; m_rel = 0; m_tone = 0; m_pf = 0;
        m_half = 0; m_left = 0; m_elapsed = 0;
        m_level = 0; m_pend = 0; m_pwm = 0;
      end else begin
        m_pwm = (m_pwm + 1) % (1 << LW);
        if (!m_act) begin
          if (v && n != 0) begin
            m_act = 1; m_rel = 0;
            m_half = (n < MH) ? MH : n;
            m_left = m_half;
            m_tone = 1;
            m_level = FULL;
          end
        end else begin
          acc = v && !m_pf;
          was_rel = m_rel;
          loaded = 0;
          if (m_left == 1) begin
            m_tone = !m_tone;
            if (m_pf) begin
              m_pf = 0;
              if (m_pend != 0) begin
                loaded = 1;
                m_half = (m_pend < MH) ? MH : m_pend;
                m_level = FULL;
                m_rel = 0;
                m_elapsed = 0;
              end else if (!m_rel) begin
                m_rel = 1;
                m_elapsed = 0;
              end
            end
            m_left = m_half;
          end else begin
            m_left--;
          end
          if (acc) begin
            m_pf = 1;
            m_pend = n;
          end
          if (was_rel && !loaded) begin
            m_elapsed++;
            if (m_elapsed % RS == 0) m_level--;
            if (m_level == 0) begin
              m_act = 0; m_rel = 0; m_tone = 0; m_pf = 0;
            end
          end
        end
      end
      e.spk     = m_tone && (m_pwm < m_level);
      e.tone    = m_tone;
      e.playing = m_act;
      e.ready   = !m_pf;
      e.level   = m_level;
      sbq.push_back(e);
    end
  endtask

  task chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0d want=%0d",
                  nm, mon_cyc, act, exp_v);
  endtask

  always @(negedge clk) begin
    exp_t e;
    mon_cyc++;
    if (sbq.size() == 0) begin
      chk("scoreboard_underflow", 0, 1);
    end else begin
      e = sbq.pop_front();
      chk("spk",        int'(spk),        int'(e.spk));
      chk("tone_out",   int'(tone_out),   int'(e.tone));
      chk("level",      int'(level),      e.level);
      chk("playing",    int'(playing),    int'(e.playing));
      chk("note_ready", int'(note_ready), int'(e.ready));
    end
  end

  task cyc(input bit rst, input bit v, input int n);
    reset      = rst;
    note_valid = v;
    note       = NOTE_W'(n);
    model_step(rst, v, n);
    @(posedge clk);
    #2;
  endtask

  task idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    cyc(0, 1, 4);
    idle(9);
    cyc(0, 1, 10);
    idle(30);
    cyc(0, 1, 0);
    idle(140);
    cyc(0, 1, 1);
    idle(10);
    cyc(0, 1, 0);
    idle(52);
    cyc(0, 1, 6);
    idle(20);
    cyc(0, 1, 5);
    cyc(1, 1, 7);
    cyc(1, 1, 7);
    idle(4);
    for (int i = 0; i < 2500; i++) begin
      bit r;
      bit v;
      int n;
      r = ($urandom % 400) == 0;
      v = ($urandom % 6) == 0;
      n = (($urandom % 4) == 0) ? 0 : int'($urandom_range(1, 9));
      cyc(r, v, n);
    end
    idle(2);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
